prog_ctr: RTL and testbench

- Program counter and fetch sequencer directly upstream of the instruction ROM.
- Drives the ROM address `prog_ctr_out` every cycle.
- Sequences launch, run and halt of the program.
- Applies next-PC selection from the control unit: increment, absolute jump or conditional relative branch, each stallable.

---
 rtl/prog_ctr_pkg.sv | 22 ++
 rtl/prog_ctr_ret_stack.sv | 53 +++++
 rtl/prog_ctr.sv | 145 ++++++++++++++
 tb/tb_prog_ctr.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_ctr_pkg.sv
// Shared types and default sizes for the program counter / fetch sequencer.
package prog_ctr_pkg;

    localparam int unsigned DEF_D         = 12;
    localparam int unsigned DEF_OFS_W     = 8;
    localparam int unsigned DEF_STK_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_INC,
        NPC_JMP,
        NPC_BR,
        NPC_RET
    } npc_sel_e;

endpackage

// File: rtl/prog_ctr_ret_stack.sv
// LIFO of return addresses; push is dropped when full, pop is dropped when empty.
module prog_ctr_ret_stack #(
    parameter int unsigned D     = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [D-1:0] push_data_i,
    output logic [D-1:0] tos_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned SpW  = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [D-1:0]   mem_q [DEPTH];
    logic [SpW-1:0] sp_q, sp_d;
    logic [IdxW-1:0] wr_idx, tos_idx;

    assign full_o  = (sp_q == SpW'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign wr_idx  = IdxW'(sp_q);
    assign tos_idx = IdxW'(sp_q - 1'b1);
    assign tos_o   = mem_q[tos_idx];

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage needs no reset: entries are only read below the stack pointer.
    always_ff @(posedge clk) begin
        if (!reset && push_i && !full_o) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer feeding the instruction ROM.
// Define CALL_STACK_EN to enable call/return with a hardware return stack.
module prog_ctr
    import prog_ctr_pkg::*;
#(
    parameter int unsigned D         = DEF_D,
    parameter int unsigned OFS_W     = DEF_OFS_W,
    parameter int unsigned STK_DEPTH = DEF_STK_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             jump_en,
    input  logic             branch_en,
    input  logic             taken,
    input  logic [D-1:0]     target,
    input  logic [OFS_W-1:0] offset,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [D-1:0]     prog_ctr_out,
    output logic             running,
    output logic             done,
    output logic             stack_err
);

    state_e       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         running_q, done_q;
    npc_sel_e     npc_sel;
    logic [D-1:0] off_ext;
    logic [D-1:0] tos;
    logic         stk_push, stk_pop, stk_full, stk_empty;
    logic         err_q, err_d;

    assign off_ext = D'($signed(offset));

`ifdef CALL_STACK_EN
    prog_ctr_ret_stack #(
        .D     (D),
        .DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (stk_push),
        .pop_i       (stk_pop),
        .push_data_i (pc_q + 1'b1),
        .tos_o       (tos),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );
`else
    logic unused_stack_in;
    assign unused_stack_in = ^{call_en, ret_en, stk_push, stk_pop, 1'(STK_DEPTH)};
    assign tos       = '0;
    assign stk_full  = 1'b0;
    assign stk_empty = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        npc_sel  = NPC_HOLD;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (!stall) begin
                    if (halt_req) begin
                        state_d = DONE;
`ifdef CALL_STACK_EN
                    end else if (ret_en) begin
                        if (stk_empty) begin
                            err_d   = 1'b1;
                            npc_sel = NPC_INC;
                        end else begin
                            stk_pop = 1'b1;
                            npc_sel = NPC_RET;
                        end
                    end else if (call_en) begin
                        // The jump happens even when the return address is lost.
                        if (stk_full) err_d = 1'b1;
                        else          stk_push = 1'b1;
                        npc_sel = NPC_JMP;
`endif
                    end else if (jump_en) begin
                        npc_sel = NPC_JMP;
                    end else if (branch_en && taken) begin
                        npc_sel = NPC_BR;
                    end else begin
                        npc_sel = NPC_INC;
                    end
                end
            end
            DONE: begin
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        unique case (npc_sel)
            NPC_INC:  pc_d = pc_q + 1'b1;
            NPC_JMP:  pc_d = target;
            NPC_BR:   pc_d = pc_q + off_ext;
            NPC_RET:  pc_d = tos;
            default:  pc_d = pc_q;
        endcase
        if (state_q != RUN && state_d == RUN) pc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
            err_q     <= err_d;
        end
    end

    assign prog_ctr_out = pc_q;
    assign running      = running_q;
    assign done         = done_q;
`ifdef CALL_STACK_EN
    assign stack_err    = err_q;
`else
    assign stack_err    = 1'b0;
    logic unused_err;
    assign unused_err   = err_q ^ err_d ^ stk_full ^ stk_empty ^ (|tos);
`endif

endmodule

// File: tb/tb_prog_ctr.sv
// Directed-vector bench for prog_ctr; call/return checks run only with CALL_STACK_EN.
module tb_prog_ctr;

    logic        clk;
    logic        reset, start, stall, halt_req, jump_en, branch_en, taken, call_en, ret_en;
    logic [11:0] target;
    logic [7:0]  offset;
    logic [11:0] prog_ctr_out;
    logic        running, done, stack_err;

    int n_total = 0;
    int n_bad   = 0;

    prog_ctr u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .halt_req     (halt_req),
        .jump_en      (jump_en),
        .branch_en    (branch_en),
        .taken        (taken),
        .target       (target),
        .offset       (offset),
        .call_en      (call_en),
        .ret_en       (ret_en),
        .prog_ctr_out (prog_ctr_out),
        .running      (running),
        .done         (done),
        .stack_err    (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; halt_req = 0; jump_en = 0; branch_en = 0; taken = 0;
        call_en = 0; ret_en = 0; target = '0; offset = '0;
    endtask

    task automatic do_jump(input logic [11:0] t);
        jump_en = 1; target = t;
        step();
        jump_en = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step(); step();
        check("rst_pc", 32'(prog_ctr_out), 0);
        check("rst_running", 32'(running), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(stack_err), 0);
        reset = 0;

        jump_en = 1; target = 12'd33;
        step();
        check("idle_hold_pc", 32'(prog_ctr_out), 0);
        check("idle_not_running", 32'(running), 0);
        jump_en = 0;

        start = 1;
        step();
        start = 0;
        check("launch_pc", 32'(prog_ctr_out), 0);
        check("launch_running", 32'(running), 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("inc_%0d", i), 32'(prog_ctr_out), 32'(i));
        end
        check("run_done", 32'(done), 0);

        do_jump(12'd10);
        check("jump_10", 32'(prog_ctr_out), 10);
        do_jump(12'd100);
        check("jump_100", 32'(prog_ctr_out), 100);
        branch_en = 1; taken = 1; offset = 8'hFC;
        step();
        check("branch_m4", 32'(prog_ctr_out), 96);
        taken = 0;
        step();
        check("branch_not_taken", 32'(prog_ctr_out), 97);
        branch_en = 0;
        offset = 8'h05;
        branch_en = 1; taken = 1;
        step();
        check("branch_p5", 32'(prog_ctr_out), 102);
        branch_en = 0; taken = 0;

        do_jump(12'd4095);
        step();
        check("wrap_inc", 32'(prog_ctr_out), 0);
        do_jump(12'd1);
        branch_en = 1; taken = 1; offset = 8'hFE;
        step();
        check("wrap_branch", 32'(prog_ctr_out), 4095);
        branch_en = 0; taken = 0;

        do_jump(12'd7);
        stall = 1; jump_en = 1; target = 12'd50; halt_req = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_pc_%0d", i), 32'(prog_ctr_out), 7);
        end
        check("stall_keeps_run", 32'(running), 1);
        stall = 0; jump_en = 0; halt_req = 0;
        step();
        check("after_stall", 32'(prog_ctr_out), 8);

        start = 1;
        step();
        start = 0;
        check("start_in_run", 32'(prog_ctr_out), 9);

`ifndef CALL_STACK_EN
        call_en = 1; ret_en = 1; target = 12'd200;
        step();
        call_en = 0; ret_en = 0;
        check("call_ignored", 32'(prog_ctr_out), 10);
        check("err_tied", 32'(stack_err), 0);
`endif

        do_jump(12'd20);
        halt_req = 1;
        step();
        halt_req = 0;
        check("halt_pc", 32'(prog_ctr_out), 20);
        check("halt_done", 32'(done), 1);
        check("halt_running", 32'(running), 0);
        jump_en = 1; target = 12'd99;
        for (int i = 0; i < 10; i++) step();
        jump_en = 0;
        check("done_hold_pc", 32'(prog_ctr_out), 20);
        check("done_hold", 32'(done), 1);

        start = 1;
        step();
        start = 0;
        check("relaunch_pc", 32'(prog_ctr_out), 0);
        check("relaunch_running", 32'(running), 1);
        check("relaunch_done", 32'(done), 0);

        do_jump(12'd30);
        reset = 1;
        step();
        reset = 0;
        check("midrun_rst_pc", 32'(prog_ctr_out), 0);
        check("midrun_rst_running", 32'(running), 0);
        step();
        check("midrun_rst_idle", 32'(prog_ctr_out), 0);

`ifdef CALL_STACK_EN
        start = 1;
        step();
        start = 0;
        do_jump(12'd5);
        call_en = 1; target = 12'd200;
        step();
        call_en = 0;
        check("call_pc", 32'(prog_ctr_out), 200);
        ret_en = 1;
        step();
        ret_en = 0;
        check("ret_pc", 32'(prog_ctr_out), 6);
        check("ret_no_err", 32'(stack_err), 0);

        for (int i = 0; i < 5; i++) begin
            call_en = 1; target = 12'(300 + 10 * i);
            step();
            check($sformatf("nest_err_%0d", i), 32'(stack_err), (i == 4) ? 1 : 0);
        end
        call_en = 0;
        check("overflow_jump", 32'(prog_ctr_out), 340);
        ret_en = 1;
        step();
        ret_en = 0;
        check("ret_after_full", 32'(prog_ctr_out), 321);
        check("err_sticky", 32'(stack_err), 1);

        reset = 1;
        step();
        reset = 0;
        check("err_cleared", 32'(stack_err), 0);
        start = 1;
        step();
        start = 0;
        ret_en = 1;
        step();
        ret_en = 0;
        check("underflow_pc", 32'(prog_ctr_out), 1);
        check("underflow_err", 32'(stack_err), 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
